// File: rtl/note_spawn_scheduler.sv
// Drums Hero note spawn scheduler: beat timer, song lifecycle FSM and the
// pending-note FIFO that the hit-judge drains as notes reach the strike line.
module note_spawn_scheduler #(
    parameter int TICKS_PER_BEAT = 25000000,
    parameter int DEPTH          = 8,
    parameter int NOTES_PER_SONG = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_pause,
    input  logic [4:0]               i_pattern_in,
    output logic                     o_spawn_valid,
    output logic [4:0]               o_spawn_pattern,
    input  logic                     i_q_pop,
    output logic [4:0]               o_q_head,
    output logic                     o_q_valid,
    output logic [$clog2(DEPTH):0]   o_q_count,
    output logic                     o_overflow,
    output logic [6:0]               o_notes_spawned,
    output logic                     o_busy,
    output logic                     o_song_done
);

    localparam int BEAT_W = $clog2(TICKS_PER_BEAT);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(TICKS_PER_BEAT - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [6:0]        SONG_LAST = 7'(NOTES_PER_SONG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [BEAT_W-1:0]   r_beat_cnt;
    logic                r_spawn_valid;
    logic [4:0]          r_spawn_pattern;
    logic [6:0]          r_notes;
    logic                r_overflow;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [4:0]          r_mem [DEPTH];

    logic                w_terminal;
    logic                w_clear;
    logic                w_cnt_en;
    logic                w_spawn;
    logic [4:0]          w_note;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;

    assign w_terminal = (r_beat_cnt == BEAT_LAST);
    // A silent beat would be unplayable, so an all-zero mask becomes lane 0.
    assign w_note     = (i_pattern_in == 5'd0) ? 5'b00001 : i_pattern_in;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = i_q_pop && !w_empty && (r_state != S_IDLE);
    assign w_push     = w_spawn && (!w_full || w_pop);

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_cnt_en    = 1'b0;
        w_spawn     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                    w_clear     = 1'b1;
                end
            end
            S_RUN: begin
                w_cnt_en = 1'b1;
                if (w_terminal) begin
                    w_spawn = 1'b1;
                    if (r_notes + 7'd1 == SONG_LAST)
                        w_state_nxt = S_DRAIN;
                    else if (i_pause)
                        w_state_nxt = S_PAUSED;
                end else if (i_pause) begin
                    w_state_nxt = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (!i_pause)
                    w_state_nxt = S_RUN;
            end
            S_DRAIN: begin
                if (w_empty)
                    w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= S_IDLE;
            r_beat_cnt      <= '0;
            r_spawn_valid   <= 1'b0;
            r_spawn_pattern <= 5'd0;
            r_notes         <= 7'd0;
            r_overflow      <= 1'b0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_spawn_valid <= w_spawn;
            if (w_clear) begin
                r_beat_cnt <= '0;
                r_notes    <= 7'd0;
                r_overflow <= 1'b0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_cnt_en)
                    r_beat_cnt <= w_terminal ? '0 : r_beat_cnt + 1'b1;
                if (w_spawn) begin
                    r_spawn_pattern <= w_note;
                    r_notes         <= r_notes + 7'd1;
                end
                // A full FIFO drops the new note but the spawn still counts.
                if (w_spawn && w_full && !w_pop)
                    r_overflow <= 1'b1;
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && !w_clear && w_push)
            r_mem[r_wr_ptr] <= w_note;
    end

    assign o_spawn_valid   = r_spawn_valid;
    assign o_spawn_pattern = r_spawn_pattern;
    assign o_q_head        = w_empty ? 5'd0 : r_mem[r_rd_ptr];
    assign o_q_valid       = !w_empty;
    assign o_q_count       = r_count;
    assign o_overflow      = r_overflow;
    assign o_notes_spawned = r_notes;
    assign o_busy          = (r_state == S_RUN) || (r_state == S_PAUSED) ||
                             (r_state == S_DRAIN);
    assign o_song_done     = (r_state == S_DONE);

endmodule

// File: tb/tb_note_spawn_scheduler.sv
// Bench for note_spawn_scheduler (4 ticks/beat, 4-deep FIFO, 6 notes/song):
// expected spawns and pops are queued by the stimulus and checked by a monitor.
module tb_note_spawn_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [4:0] pattern_in = 5'd0;
    logic       q_pop = 1'b0;
    logic       spawn_valid;
    logic [4:0] spawn_pattern;
    logic [4:0] q_head;
    logic       q_valid;
    logic [2:0] q_count;
    logic       overflow;
    logic [6:0] notes_spawned;
    logic       busy;
    logic       song_done;

    note_spawn_scheduler #(
        .TICKS_PER_BEAT(4),
        .DEPTH(4),
        .NOTES_PER_SONG(6)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .i_pause(pause),
        .i_pattern_in(pattern_in),
        .o_spawn_valid(spawn_valid),
        .o_spawn_pattern(spawn_pattern),
        .i_q_pop(q_pop),
        .o_q_head(q_head),
        .o_q_valid(q_valid),
        .o_q_count(q_count),
        .o_overflow(overflow),
        .o_notes_spawned(notes_spawned),
        .o_busy(busy),
        .o_song_done(song_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         e;
        logic [4:0] p;
    } spawn_t;

    spawn_t     exp_spawn[$];
    logic [4:0] exp_pop[$];
    int         edge_n = 0;
    int         tests  = 0;
    int         fails  = 0;
    int         s;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " spawn_valid"}, 32'(spawn_valid), 0);
        chk({tag, " spawn_pattern"}, 32'(spawn_pattern), 0);
        chk({tag, " q_head"}, 32'(q_head), 0);
        chk({tag, " q_valid"}, 32'(q_valid), 0);
        chk({tag, " q_count"}, 32'(q_count), 0);
        chk({tag, " overflow"}, 32'(overflow), 0);
        chk({tag, " notes_spawned"}, 32'(notes_spawned), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " song_done"}, 32'(song_done), 0);
    endtask

    // Leaves the caller at #1 after the edge that sampled start; s = that edge.
    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s = edge_n;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Monitor: spawn pulses and accepted pops against the queued expectations.
    spawn_t     m_sp;
    logic [4:0] m_pp;
    always @(negedge clk) begin
        if (spawn_valid) begin
            tests++;
            if (exp_spawn.size() == 0) begin
                fails++;
                $display("FAIL spawn unexpected: pattern %b at edge %0d", spawn_pattern, edge_n);
            end else begin
                m_sp = exp_spawn.pop_front();
                if (spawn_pattern !== m_sp.p || edge_n != m_sp.e) begin
                    fails++;
                    $display("FAIL spawn: got %b at edge %0d expected %b at edge %0d",
                             spawn_pattern, edge_n, m_sp.p, m_sp.e);
                end
            end
        end
        if (q_pop && q_valid) begin
            tests++;
            if (exp_pop.size() == 0) begin
                fails++;
                $display("FAIL pop unexpected: head %b at edge %0d", q_head, edge_n);
            end else begin
                m_pp = exp_pop.pop_front();
                if (q_head !== m_pp) begin
                    fails++;
                    $display("FAIL pop head: got %b expected %b at edge %0d", q_head, m_pp, edge_n);
                end
            end
        end
    end

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        chk_reset("reset");
        rst = 1'b0;

        // 1: constant pattern, no pops, overflow after the 5th spawn
        pattern_in = 5'b00110;
        do_start();
        for (int k = 1; k <= 6; k++) exp_spawn.push_back('{s + 4*k, 5'b00110});
        for (int t = 1; t <= 26; t++) begin
            step();
            if (t % 4 == 0) begin
                chk("s1 q_count", 32'(q_count), (t / 4 > 4) ? 4 : t / 4);
                chk("s1 notes", 32'(notes_spawned), t / 4);
                chk("s1 overflow", 32'(overflow), (t / 4 >= 5) ? 1 : 0);
            end
            if (t == 25) begin
                chk("s1 busy drain", 32'(busy), 1);
                chk("s1 not done", 32'(song_done), 0);
            end
        end

        // 2: drain one pop per cycle, then DONE
        q_pop = 1'b1;
        for (int k = 0; k < 4; k++) exp_pop.push_back(5'b00110);
        for (int u = 1; u <= 5; u++) begin
            step();
            if (u == 4) begin
                chk("s2 q_valid", 32'(q_valid), 0);
                chk("s2 q_head empty", 32'(q_head), 0);
                chk("s2 q_count", 32'(q_count), 0);
                chk("s2 still drain", 32'(song_done), 0);
            end
            if (u == 5) begin
                chk("s2 song_done", 32'(song_done), 1);
                chk("s2 busy", 32'(busy), 0);
                chk("s2 overflow sticky", 32'(overflow), 1);
                q_pop = 1'b0;
            end
        end

        // 3: restart from DONE with an all-zero pattern
        pattern_in = 5'b00000;
        do_start();
        exp_spawn.push_back('{s + 4, 5'b00001});
        for (int t = 1; t <= 6; t++) begin
            step();
            if (t == 1) chk("s3 overflow cleared", 32'(overflow), 0);
            if (t == 4) begin
                chk("s3 q_head", 32'(q_head), 5'b00001);
                chk("s3 q_count", 32'(q_count), 1);
                chk("s3 notes", 32'(notes_spawned), 1);
            end
            if (t == 5) begin
                chk("s3 pulse one cycle", 32'(spawn_valid), 0);
                chk("s3 pattern held", 32'(spawn_pattern), 5'b00001);
                rst = 1'b1;
            end
            if (t == 6) begin
                chk("s3 reset busy", 32'(busy), 0);
                rst = 1'b0;
            end
        end

        // 4: pause delays the beat; pops accepted while paused
        pattern_in = 5'b10101;
        do_start();
        exp_spawn.push_back('{s + 14, 5'b10101});
        exp_spawn.push_back('{s + 22, 5'b10101});
        for (int t = 1; t <= 24; t++) begin
            step();
            case (t)
                1:  pause = 1'b1;
                5:  begin
                        chk("s4 paused busy", 32'(busy), 1);
                        chk("s4 paused count", 32'(q_count), 0);
                    end
                11: pause = 1'b0;
                13: chk("s4 no early spawn", 32'(notes_spawned), 0);
                14: begin
                        chk("s4 count after spawn", 32'(q_count), 1);
                        chk("s4 notes", 32'(notes_spawned), 1);
                    end
                15: pause = 1'b1;
                17: begin
                        q_pop = 1'b1;
                        exp_pop.push_back(5'b10101);
                    end
                18: begin
                        q_pop = 1'b0;
                        chk("s4 pop while paused", 32'(q_count), 0);
                        chk("s4 paused notes", 32'(notes_spawned), 1);
                    end
                19: pause = 1'b0;
                22: begin
                        chk("s4 notes resumed", 32'(notes_spawned), 2);
                        chk("s4 count resumed", 32'(q_count), 1);
                    end
                23: rst = 1'b1;
                24: rst = 1'b0;
                default: ;
            endcase
        end

        // 5: push and pop together on a full FIFO, then drain in order
        pattern_in = 5'b00011;
        do_start();
        exp_spawn.push_back('{s + 4,  5'b00011});
        exp_spawn.push_back('{s + 8,  5'b01100});
        exp_spawn.push_back('{s + 12, 5'b10000});
        exp_spawn.push_back('{s + 16, 5'b11111});
        exp_spawn.push_back('{s + 20, 5'b01010});
        exp_spawn.push_back('{s + 24, 5'b11000});
        for (int t = 1; t <= 26; t++) begin
            step();
            case (t)
                5:  pattern_in = 5'b01100;
                9:  pattern_in = 5'b10000;
                13: pattern_in = 5'b11111;
                16: begin
                        chk("s5 full count", 32'(q_count), 4);
                        chk("s5 full no ovf", 32'(overflow), 0);
                    end
                17: pattern_in = 5'b01010;
                19: begin
                        q_pop = 1'b1;
                        exp_pop.push_back(5'b00011);
                        exp_pop.push_back(5'b01100);
                        exp_pop.push_back(5'b10000);
                        exp_pop.push_back(5'b11111);
                        exp_pop.push_back(5'b01010);
                        exp_pop.push_back(5'b11000);
                    end
                20: begin
                        chk("s5 push+pop count", 32'(q_count), 4);
                        chk("s5 push+pop ovf", 32'(overflow), 0);
                        chk("s5 notes", 32'(notes_spawned), 5);
                    end
                21: pattern_in = 5'b11000;
                24: begin
                        chk("s5 drain count", 32'(q_count), 1);
                        chk("s5 drain busy", 32'(busy), 1);
                    end
                25: begin
                        q_pop = 1'b0;
                        chk("s5 empty", 32'(q_count), 0);
                    end
                26: begin
                        chk("s5 done", 32'(song_done), 1);
                        chk("s5 ovf never", 32'(overflow), 0);
                    end
                default: ;
            endcase
        end

        // 6: reset mid-run with start held, then a fresh song
        pattern_in = 5'b00111;
        do_start();
        for (int k = 1; k <= 3; k++) exp_spawn.push_back('{s + 4*k, 5'b00111});
        for (int t = 1; t <= 15; t++) begin
            step();
            if (t == 12) chk("s6 count before rst", 32'(q_count), 3);
            if (t == 13) begin
                rst   = 1'b1;
                start = 1'b1;
            end
            if (t == 14) chk_reset("s6 mid-run rst");
            if (t == 15) begin
                chk("s6 start ignored in rst", 32'(busy), 0);
                rst   = 1'b0;
                start = 1'b0;
            end
        end
        do_start();
        exp_spawn.push_back('{s + 4, 5'b00111});
        for (int t = 1; t <= 6; t++) begin
            step();
            if (t == 1) begin
                chk("s6 fresh notes", 32'(notes_spawned), 0);
                chk("s6 fresh busy", 32'(busy), 1);
            end
            if (t == 4) begin
                chk("s6 fresh first spawn", 32'(notes_spawned), 1);
                chk("s6 fresh count", 32'(q_count), 1);
            end
            if (t == 5) rst = 1'b1;
            if (t == 6) rst = 1'b0;
        end

        step();
        chk("leftover spawns", 32'(exp_spawn.size()), 0);
        chk("leftover pops", 32'(exp_pop.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
